// File: rtl/gray_frame_tx.sv
// Frame-aligned serial feeder: buffers parallel Gray words in a small FIFO and
// shifts them out MSB first on a fixed WIDTH-cycle cadence, idle frames as zeros.
module gray_frame_tx #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         ser_out,
  output logic                         ser_valid,
  output logic                         frame_start,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [CNT_W-1:0]             frame_count
);

  localparam int LVL_W  = $clog2(DEPTH+1);
  localparam int SLOT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SLOT_W-1:0] slot;
  logic [WIDTH-1:0]  shreg;
  logic              cur_valid;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  logic load;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign load     = (slot == SLOT_W'(WIDTH-1));
  // in_ready reflects the pre-edge level only; a pop on this edge frees space next cycle.
  assign in_ready = (level < LVL_W'(DEPTH)) && rst_n;
  assign push     = in_valid && in_ready;
  assign pop      = load && (level != '0);

  assign ser_out     = shreg[WIDTH-1];
  assign ser_valid   = cur_valid;
  assign frame_start = (slot == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot        <= SLOT_W'(WIDTH-1);
      shreg       <= '0;
      cur_valid   <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level       <= '0;
      frame_count <= '0;
    end else begin
      if (load) begin
        slot <= '0;
        if (pop) begin
          shreg       <= mem[rd_ptr];
          cur_valid   <= 1'b1;
          rd_ptr      <= ptr_inc(rd_ptr);
          frame_count <= frame_count + 1'b1;
        end else begin
          shreg     <= '0;
          cur_valid <= 1'b0;
        end
      end else begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
        slot  <= slot + 1'b1;
      end

      if (push) wr_ptr <= ptr_inc(wr_ptr);

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by level and the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_gray_frame_tx.sv
// Scoreboard bench for gray_frame_tx: a cycle model predicts accepted words and
// launched frames; a negedge monitor checks every frame and status output.
module tb_gray_frame_tx;

  localparam int W = 5;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [W-1:0] in_data = '0;

  logic       in_ready, ser_out, ser_valid, frame_start;
  logic [1:0] level;
  logic [7:0] frame_count;

  logic       in_ready2, ser_out2, ser_valid2, frame_start2;
  logic [1:0] level2;
  logic [1:0] frame_count2;

  gray_frame_tx #(.WIDTH(W), .DEPTH(D), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_start(frame_start), .level(level), .frame_count(frame_count)
  );

  gray_frame_tx #(.WIDTH(W), .DEPTH(D), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .ser_out(ser_out2), .ser_valid(ser_valid2),
    .frame_start(frame_start2), .level(level2), .frame_count(frame_count2)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle model
  logic [W-1:0] fifo_m[$];
  logic [W-1:0] exp_q[$];
  int  slot_m = W-1;
  bit  cv_m = 1'b0;
  int  fc_m = 0;
  bit  last_acc = 1'b0;

  always @(posedge clk) begin
    bit acc;
    acc = 1'b0;
    if (!rst_n) begin
      slot_m = W-1;
      cv_m = 1'b0;
      fc_m = 0;
      fifo_m.delete();
      exp_q.delete();
    end else begin
      acc = in_valid && (fifo_m.size() < D);
      if (slot_m == W-1) begin
        slot_m = 0;
        if (fifo_m.size() > 0) begin
          exp_q.push_back(fifo_m.pop_front());
          cv_m = 1'b1;
          fc_m++;
        end else begin
          cv_m = 1'b0;
        end
      end else begin
        slot_m++;
      end
      if (acc) fifo_m.push_back(in_data);
    end
    last_acc = acc;
  end

  // Monitor
  logic [W-1:0] bits1, bits2;
  int bitcnt = 0;

  always @(negedge clk) begin
    chk("frame_start", frame_start, (slot_m == 0) ? 1 : 0);
    chk("ser_valid", ser_valid, cv_m);
    chk("level", level, fifo_m.size());
    chk("in_ready", in_ready, (rst_n && fifo_m.size() < D) ? 1 : 0);
    chk("frame_count", frame_count, fc_m % 256);
    chk("frame_count_w2", frame_count2, fc_m % 4);
    if (!ser_valid) begin
      bitcnt = 0;
      chk("idle_ser_out", ser_out, 0);
    end else begin
      if (frame_start) bitcnt = 0;
      bits1 = {bits1[W-2:0], ser_out};
      bits2 = {bits2[W-2:0], ser_out2};
      bitcnt++;
      if (bitcnt == W) begin
        bitcnt = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          chk("frame_word", bits1, e);
          chk("frame_word_w2", bits2, e);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] w);
    in_valid = 1'b1;
    in_data = w;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_for(input int sl, input int lv, input string name);
    for (int i = 0; i < 60; i++) begin
      if (slot_m == sl && fifo_m.size() == lv) return;
      step();
    end
    chk(name, 0, 1);
  endtask

  int pulses;

  initial begin
    // single word
    do_reset();
    send(5'b10110);
    repeat (15) step();
    chk("t1_frame_count", frame_count, 1);

    // idle stream
    do_reset();
    pulses = 0;
    repeat (40) begin
      step();
      if (frame_start) pulses++;
      chk("t2_ser_out", ser_out, 0);
    end
    chk("t2_pulses", pulses, 8);
    chk("t2_frame_count", frame_count, 0);
    chk("t2_in_ready", in_ready, 1);

    // held in_valid, back-to-back frames
    do_reset();
    send(5'b00001);
    send(5'b11111);
    send(5'b01010);
    repeat (25) step();
    chk("t3_frame_count", frame_count, 3);

    // full FIFO on a load edge
    do_reset();
    send(5'b10011);
    send(5'b01101);
    send(5'b11001);
    wait_for(W-1, 2, "t4_wait");
    in_valid = 1'b1;
    in_data = 5'b11100;
    step();
    in_valid = 1'b0;
    chk("t4_level", level, 1);
    chk("t4_in_ready", in_ready, 1);
    repeat (20) step();

    // reset mid-frame
    do_reset();
    send(5'b00111);
    send(5'b10101);
    send(5'b01110);
    wait_for(2, 2, "t5_wait");
    rst_n = 1'b0;
    step();
    chk("t5_ser_out", ser_out, 0);
    chk("t5_ser_valid", ser_valid, 0);
    chk("t5_frame_start", frame_start, 0);
    chk("t5_level", level, 0);
    chk("t5_in_ready", in_ready, 0);
    rst_n = 1'b1;
    repeat (15) step();
    chk("t5_frame_count", frame_count, 0);

    // counter wrap
    do_reset();
    send(5'b00011);
    send(5'b11110);
    send(5'b10001);
    send(5'b01011);
    send(5'b11010);
    repeat (30) step();
    chk("t6_frame_count_w2", frame_count2, 1);
    chk("t6_frame_count", frame_count, 5);
    chk("t6_leftover", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
